lfc_ram_responder: RTL
======================

// Module: lfc_ram_responder
// PURPOSE
//  Banked RAM-side responder for the lockup-free cache (LFC) memory port. It accepts
//  per-bank read/write requests (REN/WEN, addr, store) from the cache, holds each for a
//  programmable latency and returns one-cycle completion pulses with read data. It is
//  the behavioural main-memory endpoint for LFC RTL simulation and UVM benches.
// PARAMETERS
//  NUM_BANKS   4    independent request channels, one per cache bank
//  LATENCY     4    request-sample edge to complete-cycle distance in cycles; >=1
//  MEM_WORDS   256  32-bit words in the shared backing store; power of 2
// PORTS
//  clk               in   1             system clock, rising edge
//  n_rst             in   1             asynchronous active-low reset
//  ram_mem_REN       in   NUM_BANKS     per-bank read request, level, held until complete
//  ram_mem_WEN       in   NUM_BANKS     per-bank write request, level, held until complete
//  ram_mem_addr      in   NUM_BANKSx32  per-bank byte address
//  ram_mem_store     in   NUM_BANKSx32  per-bank write data
//  ram_mem_data      out  NUM_BANKSx32  per-bank read data, valid with complete
//  ram_mem_complete  out  NUM_BANKS     per-bank one-cycle completion pulse
//  bank_busy         out  NUM_BANKS     bank has an accepted request in flight
//  dual_req_err      out  NUM_BANKS     sticky: REN and WEN sampled together
// BEHAVIOUR
//  - Reset: all outputs 0, every bank FSM -> IDLE, backing store cleared to 0. Reset is
//    async; an assert mid-request aborts the request with no completion and no write.
//  - Per-bank FSM states IDLE -> WAIT -> DONE -> IDLE.
//    IDLE: if REN|WEN at edge T, latch op/addr/store, load cnt = LATENCY-1, set bank_busy.
//      Go to DONE if cnt==0, else WAIT.
//    WAIT: cnt decrements per edge; at cnt==1 go to DONE. REN/WEN/addr/store not re-sampled.
//    DONE: complete=1 for exactly this cycle (cycle T+LATENCY). On a read, data = mem[idx].
//      On a write, mem[idx] <= latched store at the end of this cycle; data = 0.
//      Next edge -> IDLE, bank_busy=0. complete and data return to 0.
//  - Requests are sampled only in IDLE. REN/WEN still high in the cycle after DONE is a
//    new request (cache must deassert in that cycle). Minimum request-to-request spacing
//    per bank is LATENCY+1 cycles.
//  - Both REN and WEN high when sampled: write is performed; dual_req_err[b] set, cleared
//    only by reset.
//  - Address: idx = addr[$clog2(MEM_WORDS)+1:2]. addr[1:0] ignored; upper bits ignored,
//    so out-of-range addresses alias (wrap) modulo MEM_WORDS words.
//  - Same-cycle conflicts between banks in DONE: reads return the pre-write value; multiple
//    writes to one idx commit the highest bank index's data.
//  - Banks are fully independent; any subset may be in any state simultaneously.
// CONFIGURATION
//  LFC_RAM_RAND_LAT_EN defined: each bank owns an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed =
//  bank index + 1, advances every cycle incl. idle). On acceptance, cnt loads
//  LATENCY-1 + lfsr[1:0], giving 0-3 extra cycles per request. LFSRs reset to seed.
//  Not defined: latency is exactly LATENCY for every request; no LFSR logic exists.
// TESTING
//  1 Reset, then REN[0]=1 addr=0x0000_0010 held -> complete[0] high only in cycle T+4,
//    data[0]=0x0, bank_busy[0] high cycles T+1..T+4.
//  2 WEN[1] addr=0x10 store=0xDEAD_BEEF, then REN[2] addr=0x10 -> data[2]=0xDEAD_BEEF.
//  3 Wrap: write 0xA5A5_0001 to addr 0x0000_0404 (MEM_WORDS=256), read addr 0x0000_0004
//    -> 0xA5A5_0001; read addr 0x0000_0007 -> same word.
//  4 Banks 0 and 3 write idx 5 with 0x1111 / 0x3333 completing same cycle, bank 1 reads
//    idx 5 in that cycle -> bank 1 gets old 0x0; later read of idx 5 -> 0x3333.
//  5 REN[0]=WEN[0]=1 store=0x77 -> write performed, dual_req_err[0]=1 until n_rst.
//  6 n_rst pulsed 2 cycles into a write -> complete never asserts, word stays 0, all
//    outputs 0; with LFC_RAM_RAND_LAT_EN, 100 reads show latency in [4,7], all values hit.

Source files
------------

// File: rtl/lfc_ram_responder_if.sv
// ----------------------------------------------------------------------------
// lfc_ram_responder_if
// Memory-port bundle between the lockup-free cache (master) and the banked
// RAM responder (slave). One request/response channel per cache bank.
//
//   ram_mem_REN       cache -> ram  per-bank read request (level)
//   ram_mem_WEN       cache -> ram  per-bank write request (level)
//   ram_mem_addr      cache -> ram  per-bank byte address
//   ram_mem_store     cache -> ram  per-bank write data
//   ram_mem_data      ram -> cache  per-bank read data, valid with complete
//   ram_mem_complete  ram -> cache  per-bank one-cycle completion pulse
// ----------------------------------------------------------------------------
interface lfc_ram_responder_if #(
  parameter int NUM_BANKS = 4
);
  logic [NUM_BANKS-1:0]       ram_mem_REN;
  logic [NUM_BANKS-1:0]       ram_mem_WEN;
  logic [NUM_BANKS-1:0][31:0] ram_mem_addr;
  logic [NUM_BANKS-1:0][31:0] ram_mem_store;
  logic [NUM_BANKS-1:0][31:0] ram_mem_data;
  logic [NUM_BANKS-1:0]       ram_mem_complete;

  modport master (
    output ram_mem_REN, ram_mem_WEN, ram_mem_addr, ram_mem_store,
    input  ram_mem_data, ram_mem_complete
  );

  modport slave (
    input  ram_mem_REN, ram_mem_WEN, ram_mem_addr, ram_mem_store,
    output ram_mem_data, ram_mem_complete
  );
endinterface

// File: rtl/lfc_ram_responder.sv
// ----------------------------------------------------------------------------
// lfc_ram_responder
// Behavioural banked main-memory endpoint for the lockup-free cache. Each bank
// accepts a read or write request, holds it for a programmable latency and
// then produces a one-cycle completion pulse (with read data on reads).
// All banks share one word-addressed backing store.
//
// Parameters
//   NUM_BANKS  independent request channels (one per cache bank)
//   LATENCY    request-sample edge to completion-cycle distance, >= 1
//   MEM_WORDS  32-bit words in the backing store, power of 2
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   ram           lfc_ram_responder_if.slave request/response bundle
//   bank_busy     bank holds an accepted request in flight
//   dual_req_err  sticky per bank: REN and WEN sampled together
//
// Optional feature macro: LFC_RAM_RAND_LAT_EN
//   When defined, each bank adds 0..3 extra cycles per request, taken from a
//   per-bank 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed = bank index + 1).
// ----------------------------------------------------------------------------
module lfc_ram_responder #(
  parameter int NUM_BANKS = 4,
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  n_rst,
  lfc_ram_responder_if.slave    ram,
  output logic [NUM_BANKS-1:0]  bank_busy,
  output logic [NUM_BANKS-1:0]  dual_req_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  // Room for LATENCY-1 plus up to 3 random extra cycles.
  localparam int CNT_W = $clog2(LATENCY + 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q  [NUM_BANKS];
  state_t           state_d  [NUM_BANKS];
  logic [CNT_W-1:0] cnt_q    [NUM_BANKS];
  logic [CNT_W-1:0] cnt_d    [NUM_BANKS];
  logic [CNT_W-1:0] load_cnt [NUM_BANKS];
  logic             accept   [NUM_BANKS];

  logic             op_wr_q  [NUM_BANKS];
  logic [IDX_W-1:0] idx_q    [NUM_BANKS];
  logic [31:0]      store_q  [NUM_BANKS];

  logic [31:0]      mem [MEM_WORDS];

  // Only addr[IDX_W+1:2] selects a word; the remaining bits are ignored.
  logic unused_addr_bits;
  always_comb begin
    unused_addr_bits = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      unused_addr_bits = unused_addr_bits ^ (^ram.ram_mem_addr[b]);
    end
  end

`ifdef LFC_RAM_RAND_LAT_EN
  logic [7:0] lfsr_q [NUM_BANKS];

  // Free-running per-bank LFSRs, advancing every cycle including idle ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        lfsr_q[b] <= 8'(b + 1);
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        lfsr_q[b] <= {lfsr_q[b][6:0],
                      lfsr_q[b][7] ^ lfsr_q[b][5] ^ lfsr_q[b][4] ^ lfsr_q[b][3]};
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      load_cnt[b] = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[b][1:0]);
    end
  end
`else
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      load_cnt[b] = CNT_W'(LATENCY - 1);
    end
  end
`endif

  // Per-bank FSM next state. Requests are only looked at in IDLE.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      accept[b]  = 1'b0;
      case (state_q[b])
        IDLE: begin
          if (ram.ram_mem_REN[b] || ram.ram_mem_WEN[b]) begin
            accept[b]  = 1'b1;
            cnt_d[b]   = load_cnt[b];
            state_d[b] = (load_cnt[b] == '0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt_d[b] = cnt_q[b] - 1'b1;
          if (cnt_q[b] == CNT_W'(1)) begin
            state_d[b] = DONE;
          end
        end
        DONE: begin
          cnt_d[b]   = '0;
          state_d[b] = IDLE;
        end
        default: begin
          cnt_d[b]   = '0;
          state_d[b] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= IDLE;
        cnt_q[b]   <= '0;
      end
      dual_req_err <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
        if (accept[b] && ram.ram_mem_REN[b] && ram.ram_mem_WEN[b]) begin
          dual_req_err[b] <= 1'b1;
        end
      end
    end
  end

  // Request payload; only meaningful while the bank is busy, so no reset.
  // A simultaneous REN+WEN is treated as a write.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (accept[b]) begin
        op_wr_q[b] <= ram.ram_mem_WEN[b];
        idx_q[b]   <= ram.ram_mem_addr[b][IDX_W+1:2];
        store_q[b] <= ram.ram_mem_store[b];
      end
    end
  end

  // Backing store. Writes commit on the edge that ends DONE, so same-cycle
  // readers see the old word; ascending loop order lets the highest bank win.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int w = 0; w < MEM_WORDS; w++) begin
        mem[w] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (state_q[b] == DONE && op_wr_q[b]) begin
          mem[idx_q[b]] <= store_q[b];
        end
      end
    end
  end

  // Responses decode directly from the state register, so reset clears them.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      ram.ram_mem_complete[b] = (state_q[b] == DONE);
      ram.ram_mem_data[b]     = '0;
      bank_busy[b]            = (state_q[b] != IDLE);
      if (state_q[b] == DONE && !op_wr_q[b]) begin
        ram.ram_mem_data[b] = mem[idx_q[b]];
      end
    end
  end

endmodule
